// File: rtl/guitarists_pkg.sv
// Shared types and constants for the setlist sequencer: FSM states, pattern bit
// positions and default timing parameters.
package guitarists_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT_IN,
    ST_PLAY,
    ST_SOLO
  } state_t;

  localparam int PAT_RIFF   = 1;
  localparam int PAT_GROOVE = 0;

  localparam int DEF_BEAT_DIV = 16;
  localparam int DEF_STEPS    = 8;
  localparam int DEF_COUNT_IN = 4;

endpackage

// File: rtl/setlist_sequencer_beat_divider.sv
// Tempo divider: counts 0..DIV-1 while enabled and pulses beat on the last count.
// clr has priority over en so the count restarts exactly on entry to count-in.
module beat_divider #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic beat
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign beat = en && (cnt == LAST);

endmodule

// File: rtl/setlist_sequencer.sv
// Step-pattern sequencer driving riff/groove/solo controls: count-in, looping play,
// one-pass solo on request and a stop that lands on the next pattern wrap.
module setlist_sequencer
  import guitarists_pkg::*;
#(
  parameter int BEAT_DIV = DEF_BEAT_DIV,
  parameter int STEPS    = DEF_STEPS,
  parameter int COUNT_IN = DEF_COUNT_IN
) (
  input  logic                     mclk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     solo_req,
  input  logic                     pat_we,
  input  logic [$clog2(STEPS)-1:0] pat_addr,
  input  logic [1:0]               pat_wdata,
  output logic                     riff,
  output logic                     groove,
  output logic                     solo,
  output logic                     beat,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     busy
);

  localparam int SW = $clog2(STEPS);
  localparam int CW = $clog2(COUNT_IN + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);
  localparam logic [CW-1:0] LAST_CIN  = CW'(COUNT_IN - 1);

  state_t        state;
  logic [1:0]    pat [STEPS];
  logic [CW-1:0] cin_cnt;
  logic          solo_lat;
  logic          stop_lat;
  logic [SW-1:0] nxt_step;
  logic [1:0]    nxt_pat;
  logic          start_go;
  logic          cin_abort;
  logic          wrap;

  assign busy      = (state != ST_IDLE);
  assign start_go  = (state == ST_IDLE) && start && !stop;
  assign cin_abort = (state == ST_COUNT_IN) && stop;
  assign wrap      = beat && (step == LAST_STEP);
  assign nxt_step  = step + 1'b1;
  assign nxt_pat   = pat[nxt_step];

  beat_divider #(.DIV(BEAT_DIV)) u_div (
    .clk  (mclk),
    .rst  (reset),
    .en   (busy),
    .clr  (start_go || cin_abort),
    .beat (beat)
  );

  // Reads use the pre-edge contents, so a same-beat write returns old data.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STEPS; i++) pat[i] <= '0;
    end else if (pat_we) begin
      pat[pat_addr] <= pat_wdata;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      step     <= '0;
      cin_cnt  <= '0;
      solo_lat <= 1'b0;
      stop_lat <= 1'b0;
      riff     <= 1'b0;
      groove   <= 1'b0;
      solo     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_go) begin
            state   <= ST_COUNT_IN;
            cin_cnt <= '0;
          end
        end
        ST_COUNT_IN: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (beat) begin
            if (cin_cnt == LAST_CIN) begin
              state  <= ST_PLAY;
              step   <= '0;
              riff   <= pat[0][PAT_RIFF];
              groove <= pat[0][PAT_GROOVE];
            end else begin
              cin_cnt <= cin_cnt + 1'b1;
            end
          end
        end
        ST_PLAY, ST_SOLO: begin
          if (stop) stop_lat <= 1'b1;
          if (state == ST_PLAY && solo_req) solo_lat <= 1'b1;
          if (beat) begin
            step <= nxt_step;
            // Later assignments in this branch override the latch sets above.
            if (wrap && stop_lat) begin
              state    <= ST_IDLE;
              stop_lat <= 1'b0;
              solo_lat <= 1'b0;
              riff     <= 1'b0;
              groove   <= 1'b0;
              solo     <= 1'b0;
            end else if (wrap && state == ST_SOLO) begin
              state    <= ST_PLAY;
              solo_lat <= 1'b0;
              solo     <= 1'b0;
              riff     <= nxt_pat[PAT_RIFF];
              groove   <= nxt_pat[PAT_GROOVE];
            end else if (wrap && solo_lat) begin
              state  <= ST_SOLO;
              solo   <= 1'b1;
              riff   <= 1'b1;
              groove <= 1'b0;
            end else if (state == ST_PLAY) begin
              riff   <= nxt_pat[PAT_RIFF];
              groove <= nxt_pat[PAT_GROOVE];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_setlist_sequencer.sv
// Bench for setlist_sequencer: directed vector table, hand-written corner sequences
// and a randomized run, all compared every cycle against a timeline-based model.
module tb_setlist_sequencer;

  localparam int BD    = 4;
  localparam int STEPS = 4;
  localparam int CI    = 2;

  logic       mclk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       solo_req;
  logic       pat_we;
  logic [1:0] pat_addr;
  logic [1:0] pat_wdata;
  logic       riff;
  logic       groove;
  logic       solo;
  logic       beat;
  logic [1:0] step;
  logic       busy;
  logic [6:0] dut_o;

  int total;
  int bad;

  setlist_sequencer #(.BEAT_DIV(BD), .STEPS(STEPS), .COUNT_IN(CI)) dut (
    .mclk      (mclk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .solo_req  (solo_req),
    .pat_we    (pat_we),
    .pat_addr  (pat_addr),
    .pat_wdata (pat_wdata),
    .riff      (riff),
    .groove    (groove),
    .solo      (solo),
    .beat      (beat),
    .step      (step),
    .busy      (busy)
  );

  assign dut_o = {busy, beat, solo, riff, groove, step};

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Model: a set is a timeline of t cycles since start; beats and passes follow by division.
  bit         m_act;
  int         m_t;
  bit         m_sp;
  bit         m_st;
  bit         m_solo;
  logic [1:0] m_cur;
  logic [1:0] m_pat [STEPS];

  task automatic m_reset();
    m_act = 0; m_t = 0; m_sp = 0; m_st = 0; m_solo = 0; m_cur = '0;
    for (int i = 0; i < STEPS; i++) m_pat[i] = '0;
  endtask

  task automatic m_edge();
    bit countin;
    bit beat_e;
    bit was_solo;
    int nb;
    int pb;
    if (reset) begin
      m_reset();
      return;
    end
    if (!m_act) begin
      if (start && !stop) begin
        m_act = 1; m_t = 0; m_sp = 0; m_st = 0; m_solo = 0;
      end
    end else begin
      countin  = (m_t / BD) < CI;
      beat_e   = (m_t % BD) == BD - 1;
      was_solo = m_solo;
      if (countin && stop) begin
        m_act = 0;
      end else begin
        if (beat_e) begin
          nb = m_t / BD + 1;
          if (nb >= CI) begin
            pb = nb - CI;
            if (pb > 0 && pb % STEPS == 0) begin
              if (m_st) m_act = 0;
              else if (m_solo) begin m_solo = 0; m_sp = 0; end
              else if (m_sp) m_solo = 1;
            end
            m_cur = m_pat[pb % STEPS];
          end
        end
        if (m_act && !countin) begin
          if (stop) m_st = 1;
          if (solo_req && !was_solo) m_sp = 1;
        end
        m_t++;
      end
    end
    if (pat_we) m_pat[pat_addr] = pat_wdata;
  endtask

  function automatic logic [6:0] m_out();
    int   pb;
    logic b;
    if (!m_act) return '0;
    b = (m_t % BD) == BD - 1;
    if ((m_t / BD) < CI) return {1'b1, b, 5'b00000};
    pb = m_t / BD - CI;
    return {1'b1, b, m_solo, m_solo ? 1'b1 : m_cur[1], m_solo ? 1'b0 : m_cur[0], 2'(pb % STEPS)};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (busy,beat,solo,riff,groove,step) at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    m_edge();
    #1;
    chk("cycle", dut_o, m_out());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  typedef struct {
    int         n;
    logic [6:0] exp;
  } vec_t;

  vec_t       vec [11];
  logic [1:0] pat_tbl [4];

  initial begin
    vec[0]  = '{0,  7'b1000000};
    vec[1]  = '{3,  7'b1100000};
    vec[2]  = '{4,  7'b1000000};
    vec[3]  = '{7,  7'b1100000};
    vec[4]  = '{8,  7'b1001000};
    vec[5]  = '{11, 7'b1101000};
    vec[6]  = '{12, 7'b1000101};
    vec[7]  = '{16, 7'b1001110};
    vec[8]  = '{20, 7'b1000011};
    vec[9]  = '{23, 7'b1100011};
    vec[10] = '{24, 7'b1001000};
    pat_tbl[0] = 2'b10; pat_tbl[1] = 2'b01; pat_tbl[2] = 2'b11; pat_tbl[3] = 2'b00;

    total = 0; bad = 0;
    start = 0; stop = 0; solo_req = 0; pat_we = 0; pat_addr = '0; pat_wdata = '0;
    reset = 1'b1;
    m_reset();
    run(3);
    reset = 1'b0;
    run(100);
    chk("idle_after_reset", dut_o, 7'b0);

    for (int i = 0; i < 4; i++) begin
      pat_we = 1'b1; pat_addr = 2'(i); pat_wdata = pat_tbl[i];
      tick();
    end
    pat_we = 1'b0;

    // Basic set against the vector table; n counts cycles after start is sampled.
    pulse_start();
    for (int n = 0; n <= 24; n++) begin
      for (int k = 0; k < 11; k++)
        if (vec[k].n == n) chk($sformatf("basic_n%0d", n), dut_o, vec[k].exp);
      if (n < 24) tick();
    end

    // Solo requested at step 1 plays after the current pass, then play resumes.
    run(4);
    chk("solo_req_step1", dut_o, 7'b1000101);
    solo_req = 1'b1; tick(); solo_req = 1'b0;
    run(11);
    chk("solo_enter", dut_o, 7'b1011000);
    run(15);
    chk("solo_last", dut_o, 7'b1111011);
    tick();
    chk("solo_exit_play", dut_o, 7'b1001000);

    // Stop at step 1 lands on the wrap.
    run(4);
    stop = 1'b1; tick(); stop = 1'b0;
    run(10);
    chk("stop_before_wrap", dut_o, 7'b1100011);
    tick();
    chk("stop_at_wrap", dut_o, 7'b0);

    // Stop during count-in.
    pulse_start();
    run(2);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_countin", dut_o, 7'b0);
    run(10);
    chk("stop_countin_stays", dut_o, 7'b0);

    // Stop and solo both latched: stop wins.
    pulse_start();
    run(12);
    stop = 1'b1; solo_req = 1'b1; tick(); stop = 1'b0; solo_req = 1'b0;
    run(10);
    chk("collide_pre_wrap", dut_o, 7'b1100011);
    tick();
    chk("collide_wrap_idle", dut_o, 7'b0);
    run(20);
    chk("collide_no_solo", dut_o, 7'b0);

    // Start with stop in idle stays idle.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", dut_o, 7'b0);
    run(5);
    chk("start_stop_idle_hold", dut_o, 7'b0);

    // Start while busy is ignored.
    pulse_start();
    run(4);
    pulse_start();
    run(3);
    chk("start_while_busy", dut_o, 7'b1001000);

    // Reset asynchronously in the middle of a solo pass.
    run(4);
    solo_req = 1'b1; tick(); solo_req = 1'b0;
    run(11);
    chk("solo_before_reset", dut_o, 7'b1011000);
    run(2);
    #3 reset = 1'b1;
    #1 chk("async_reset", dut_o, 7'b0);
    m_reset();
    tick();
    reset = 1'b0;
    pulse_start();
    run(8);
    for (int i = 0; i < 16; i++) begin
      chk("pattern_cleared", 7'({riff, groove}), 7'b0);
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    run(20);
    chk("post_reset_stop", dut_o, 7'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      start     = ($urandom_range(99) < 4);
      stop      = ($urandom_range(199) < 2);
      solo_req  = ($urandom_range(99) < 3);
      pat_we    = ($urandom_range(99) < 20);
      pat_addr  = 2'($urandom_range(3));
      pat_wdata = 2'($urandom_range(3));
      reset     = ($urandom_range(999) < 2);
      tick();
    end
    start = 0; stop = 0; solo_req = 0; pat_we = 0; reset = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
